// File: rtl/uart_pkg.sv
// Shared types and helpers for the parity-framed UART transmitter.
// Frame on the line: start, 8 data bits LSB-first, parity, stop.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    // Even parity makes the count of ones in data+parity even; odd makes it odd.
    function automatic logic par(input logic [DATA_BITS-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running bit-period counter: tick_o marks the last cycle of each bit.
// clr_i pins the count at zero so a new frame starts on a full bit period.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_parity_tx.sv
// Parity-framing serial transmitter. Accepts a word when idle, then drives
// start/data/parity/stop on a registered, glitch-free txd_o.
//
// Handshake: start_i is level-sampled; a word is accepted on any rising edge
// where start_i=1 and the block is idle (busy_o=0, including the done_o cycle).
// While busy_o=1, start_i and data_i are ignored and nothing is queued.
module uart_parity_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       txd_o,
    output logic [2:0] dbg_state_o
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_parity_tx: CLK_HZ/BAUD must be at least 2");
    end

    tx_state_t      state_q, state_d;
    logic [7:0]     data_q, data_d;
    logic           par_q, par_d;
    logic [2:0]     bit_q, bit_d;
    logic           txd_q, txd_d;
    logic           done_q, done_d;
    logic           tick;
    logic           baud_clr;

    // Holding the counter clear while idle makes the accept edge restart it.
    assign baud_clr = (state_q == IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (baud_clr),
        .tick_o(tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        par_d   = par_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = START;
                    data_d  = data_i;
                    par_d   = par(data_i, PARITY_ODD != 0);
                    bit_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = PARITY;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so the pin register changes
    // on the same edge as the state.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = data_d[bit_d];
            PARITY:  txd_d = par_d;
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
        done_d      = (state_q == STOP) && tick;
        busy_o      = (state_q != IDLE);
        done_o      = done_q;
        txd_o       = txd_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_uart_parity_tx.sv
// Directed bench for uart_parity_tx at 10 clocks per bit, even and odd parity.
module tb_uart_parity_tx;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] data_e, data_o;
    logic       start_e, start_o;
    logic       busy_ev, done_ev, txd_ev;
    logic       busy_od, done_od, txd_od;
    logic [2:0] dbg_e, dbg_o;

    uart_parity_tx #(.CLK_HZ(1000), .BAUD(100), .PARITY_ODD(0)) dut_even (
        .clk_i(clk), .rst_i(rst), .data_i(data_e), .start_i(start_e),
        .busy_o(busy_ev), .done_o(done_ev), .txd_o(txd_ev), .dbg_state_o(dbg_e)
    );

    uart_parity_tx #(.CLK_HZ(1000), .BAUD(100), .PARITY_ODD(1)) dut_odd (
        .clk_i(clk), .rst_i(rst), .data_i(data_o), .start_i(start_o),
        .busy_o(busy_od), .done_o(done_od), .txd_o(txd_od), .dbg_state_o(dbg_o)
    );

    int checks = 0;
    int errors = 0;

    logic line_s [0:255];
    logic busy_s [0:255];
    logic done_s [0:255];

    typedef struct {
        string      name;
        bit         odd;
        logic [7:0] d;
        logic       p;
        int         inject;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit odd, input logic st, input logic [7:0] d);
        if (odd) begin
            start_o = st;
            data_o  = d;
        end else begin
            start_e = st;
            data_e  = d;
        end
    endtask

    task automatic sample(input bit odd, input int i);
        line_s[i] = odd ? txd_od  : txd_ev;
        busy_s[i] = odd ? busy_od : busy_ev;
        done_s[i] = odd ? done_od : done_ev;
    endtask

    // Frame bit k: 0 start, 1..8 data LSB-first, 9 parity, 10 stop.
    task automatic check_bits(input string name, input int base, input logic [7:0] d, input logic p);
        for (int k = 0; k < FRAME_BITS; k++) begin
            logic exp_b;
            int   bad;
            if (k == 0)       exp_b = 1'b0;
            else if (k <= 8)  exp_b = d[k-1];
            else if (k == 9)  exp_b = p;
            else              exp_b = 1'b1;
            bad = 0;
            for (int c = 0; c < 10; c++)
                if (line_s[base + 10*k + c] !== exp_b) bad++;
            check($sformatf("%s bit%0d wrong-cycles", name, k), bad, 0);
        end
    endtask

    task automatic count_range(input int lo, input int hi, output int nb, output int nd, output int nl);
        nb = 0; nd = 0; nl = 0;
        for (int i = lo; i <= hi; i++) begin
            if (busy_s[i] === 1'b1) nb++;
            if (done_s[i] === 1'b1) nd++;
            if (line_s[i] === 1'b1) nl++;
        end
    endtask

    // One-cycle start, then n samples; sample 0 is the first start-bit cycle.
    task automatic run_frame(input bit odd, input logic [7:0] d, input int inject_at, input int n);
        drive(odd, 1'b1, d);
        step();
        for (int i = 0; i < n; i++) begin
            sample(odd, i);
            if (i == inject_at) drive(odd, 1'b1, 8'h3C);
            else                drive(odd, 1'b0, d);
            step();
        end
        drive(odd, 1'b0, d);
    endtask

    initial begin
        int nb, nd, nl;

        vt[0] = '{"A5 even",        1'b0, 8'hA5, 1'b0, -1};
        vt[1] = '{"07 even",        1'b0, 8'h07, 1'b1, -1};
        vt[2] = '{"00 odd",         1'b1, 8'h00, 1'b1, -1};
        vt[3] = '{"FF odd",         1'b1, 8'hFF, 1'b1, -1};
        vt[4] = '{"01 odd",         1'b1, 8'h01, 1'b0, -1};
        vt[5] = '{"A5 even inject", 1'b0, 8'hA5, 1'b0, 40};

        rst = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) step();
        rst = 1'b0;
        check("reset txd even", txd_ev, 1);
        check("reset busy even", busy_ev, 0);
        check("reset done even", done_ev, 0);
        check("reset state even", dbg_e, IDLE);
        check("reset txd odd", txd_od, 1);
        check("reset busy odd", busy_od, 0);

        begin
            int bad_e, bad_o;
            bad_e = 0; bad_o = 0;
            for (int i = 0; i < 50; i++) begin
                if (txd_ev !== 1'b1 || busy_ev !== 1'b0 || done_ev !== 1'b0) bad_e++;
                if (txd_od !== 1'b1 || busy_od !== 1'b0 || done_od !== 1'b0) bad_o++;
                step();
            end
            check("idle line even", bad_e, 0);
            check("idle line odd", bad_o, 0);
        end

        for (int v = 0; v < 6; v++) begin
            run_frame(vt[v].odd, vt[v].d, vt[v].inject, 130);
            check_bits(vt[v].name, 0, vt[v].d, vt[v].p);
            count_range(0, 129, nb, nd, nl);
            check({vt[v].name, " busy cycles"}, nb, 110);
            check({vt[v].name, " done pulses"}, nd, 1);
            check({vt[v].name, " done at 110"}, done_s[110], 1);
            count_range(110, 129, nb, nd, nl);
            check({vt[v].name, " idle after"}, nl, 20);
            repeat (5) step();
        end

        // Back-to-back: start held, data changed mid-frame, second word accepted in done cycle.
        drive(0, 1'b1, 8'h5A);
        step();
        for (int i = 0; i < 240; i++) begin
            sample(0, i);
            if (i == 0)   drive(0, 1'b1, 8'hC3);
            if (i == 111) drive(0, 1'b0, 8'hC3);
            step();
        end
        drive(0, 1'b0, 8'h00);
        check_bits("b2b 5A", 0, 8'h5A, 1'b0);
        check_bits("b2b C3", 111, 8'hC3, 1'b0);
        check("b2b done1", done_s[110], 1);
        check("b2b busy gap", busy_s[110], 0);
        check("b2b done2", done_s[221], 1);
        count_range(0, 239, nb, nd, nl);
        check("b2b done pulses", nd, 2);
        check("b2b busy cycles", nb, 220);
        repeat (5) step();

        // Reset in the middle of a frame.
        drive(0, 1'b1, 8'hA5);
        step();
        for (int i = 0; i < 56; i++) begin
            sample(0, i);
            drive(0, 1'b0, 8'hA5);
            step();
        end
        check("pre-reset busy", busy_ev, 1);
        rst = 1'b1;
        step();
        check("abort txd", txd_ev, 1);
        check("abort busy", busy_ev, 0);
        check("abort done", done_ev, 0);
        check("abort state", dbg_e, IDLE);
        rst = 1'b0;
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 120; i++) begin
                if (done_ev !== 1'b0 || txd_ev !== 1'b1 || busy_ev !== 1'b0) bad++;
                step();
            end
            check("abort quiet", bad, 0);
        end
        run_frame(0, 8'h96, -1, 130);
        check_bits("after reset 96", 0, 8'h96, 1'b0);
        count_range(0, 129, nb, nd, nl);
        check("after reset done pulses", nd, 1);
        check("after reset busy cycles", nb, 110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
